// File: rtl/led_fx_pkg.sv
// Shared constants for the LED effects driver: register map, per-LED mode codes, reset values.
package led_fx_pkg;

  localparam logic [1:0] REG_MODE       = 2'd0;
  localparam logic [1:0] REG_DUTY       = 2'd1;
  localparam logic [1:0] REG_BLINK_HALF = 2'd2;
  localparam logic [1:0] REG_STATUS     = 2'd3;

  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_BLINK = 2'b01;
  localparam logic [1:0] MODE_DIM   = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  localparam int unsigned BLINK_HALF_W   = 16;
  localparam logic [15:0] BLINK_HALF_RST = 16'd500;

  // A zero half-period would never toggle; treat it as one tick.
  function automatic logic [BLINK_HALF_W-1:0] blink_half_eff(input logic [BLINK_HALF_W-1:0] half);
    return (half == '0) ? BLINK_HALF_W'(1) : half;
  endfunction

endpackage

// File: rtl/led_fx_timebase.sv
// Shared timebase: prescaler tick generator plus blink half-period counter and phase.
module led_fx_timebase
  import led_fx_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [BLINK_HALF_W-1:0] blink_half,
  input  logic                    blink_half_wr,
  output logic                    tick,
  output logic                    blink_phase
);

  localparam int unsigned PRE_W = $clog2(PRESCALE_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

  logic [PRE_W-1:0]        pre_cnt;
  logic [BLINK_HALF_W-1:0] blink_cnt;
  logic [BLINK_HALF_W-1:0] half_last;

  assign tick      = (pre_cnt == PRE_LAST);
  assign half_last = blink_half_eff(blink_half) - BLINK_HALF_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // A half-period write restarts the count and swallows a coincident tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_half_wr) begin
      blink_cnt <= '0;
    end else if (tick) begin
      if (blink_cnt >= half_last) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_HALF_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_fx_driver.sv
// Per-LED pass/blink/dim/off effects between the LED PIO and the board pins,
// configured through a 2-bit-address zero-wait Avalon-MM slave.
module led_fx_driver
  import led_fx_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 4,
  parameter int unsigned PRESCALE_DIV = 50000,
  parameter int unsigned PWM_W        = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam int unsigned MODE_W = 2 * NUM_LEDS;

  logic [MODE_W-1:0]       mode_q;
  logic [PWM_W-1:0]        duty_q;
  logic [PWM_W-1:0]        pwm_cnt;
  logic [BLINK_HALF_W-1:0] blink_half_q;
  logic                    wr_en;
  logic                    blink_half_wr;
  logic                    blink_phase;
  logic                    pwm_on;
  logic [NUM_LEDS-1:0]     led_nxt;
  logic                    unused_tick;
  logic                    unused_wdata;

  assign wr_en         = chipselect && !write_n;
  assign blink_half_wr = wr_en && (address == REG_BLINK_HALF);
  assign unused_wdata  = ^writedata;

  led_fx_timebase #(
    .PRESCALE_DIV(PRESCALE_DIV)
  ) u_timebase (
    .clk          (clk),
    .reset_n      (reset_n),
    .blink_half   (blink_half_q),
    .blink_half_wr(blink_half_wr),
    .tick         (unused_tick),
    .blink_phase  (blink_phase)
  );

  // Register file; STATUS is read-only so its writes fall through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q       <= '0;
      duty_q       <= '1;
      blink_half_q <= BLINK_HALF_RST;
    end else if (wr_en) begin
      case (address)
        REG_MODE:       mode_q       <= writedata[MODE_W-1:0];
        REG_DUTY:       duty_q       <= writedata[PWM_W-1:0];
        REG_BLINK_HALF: blink_half_q <= writedata[BLINK_HALF_W-1:0];
        default:        ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  // All-ones duty is a true 100% rather than (2^W-1)/2^W.
  assign pwm_on = (&duty_q) || (pwm_cnt < duty_q);

  always_comb begin
    readdata = '0;
    case (address)
      REG_MODE:       readdata = 32'(mode_q);
      REG_DUTY:       readdata = 32'(duty_q);
      REG_BLINK_HALF: readdata = 32'(blink_half_q);
      REG_STATUS:     readdata = (32'(pwm_cnt) << 8) | 32'(blink_phase);
      default:        readdata = '0;
    endcase
  end

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (mode_q[2*i +: 2])
        MODE_PASS:  led_nxt[i] = led_in[i];
        MODE_BLINK: led_nxt[i] = led_in[i] & blink_phase;
        MODE_DIM:   led_nxt[i] = led_in[i] & pwm_on;
        MODE_OFF:   led_nxt[i] = 1'b0;
        default:    led_nxt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= '0;
    end else begin
      led_out <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_fx_driver.sv
// Self-checking bench for led_fx_driver: directed scenarios plus random traffic,
// compared each cycle against a cycle-count based behavioural model.
module tb_led_fx_driver;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;
  localparam int unsigned PW  = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [N-1:0]  led_in;
  logic [N-1:0]  led_out;

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release, registers, blink progress, expected pins
  int unsigned m_cyc;
  logic [7:0]  m_mode;
  logic [7:0]  m_duty;
  logic [15:0] m_half;
  int unsigned m_bcnt;
  logic        m_phase;
  logic [N-1:0] m_led;

  led_fx_driver #(.NUM_LEDS(N), .PRESCALE_DIV(DIV), .PWM_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .led_in(led_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_mode = 8'h00; m_duty = 8'hFF; m_half = 16'd500;
    m_bcnt = 0; m_phase = 1'b1; m_led = '0;
  endtask

  function automatic logic [31:0] ref_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'b0, m_mode};
      2'd1:    return {24'b0, m_duty};
      2'd2:    return {16'b0, m_half};
      default: return {16'b0, 8'(m_cyc % 256), 7'b0, m_phase};
    endcase
  endfunction

  // One clock edge of the specified behaviour, using pre-edge values throughout.
  task automatic model_edge();
    logic [N-1:0] nl;
    int unsigned  pwm, sel, half_eff;
    bit           on, tick, wr;
    pwm  = m_cyc % 256;
    on   = (m_duty == 8'hFF) || (pwm < m_duty);
    tick = ((m_cyc % DIV) == DIV - 1);
    wr   = chipselect && !write_n;
    for (int i = 0; i < N; i++) begin
      sel = (m_mode >> (2 * i)) & 3;
      if (sel == 0)      nl[i] = led_in[i];
      else if (sel == 1) nl[i] = led_in[i] & m_phase;
      else if (sel == 2) nl[i] = led_in[i] & on;
      else               nl[i] = 1'b0;
    end
    half_eff = (m_half == 0) ? 1 : m_half;
    if (wr && address == 2'd2) m_bcnt = 0;
    else if (tick) begin
      if (m_bcnt >= half_eff - 1) begin m_bcnt = 0; m_phase = ~m_phase; end
      else m_bcnt++;
    end
    if (wr) begin
      case (address)
        2'd0: m_mode = writedata[7:0];
        2'd1: m_duty = writedata[7:0];
        2'd2: m_half = writedata[15:0];
        default: ;
      endcase
    end
    m_led = nl;
    m_cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    chk("led_out", 32'(led_out), 32'(m_led));
    chk("readdata", readdata, ref_read(address));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cycle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic blink_period(input string tag, input int expv);
    int   last;
    int   per;
    logic p;
    last = -1; per = 0;
    for (int k = 0; k < 80; k++) begin
      p = led_out[0];
      cycle();
      if (led_out[0] !== p) begin
        if (last >= 0 && per == 0) per = k - last;
        last = k;
      end
    end
    chk(tag, 32'(per), 32'(expv));
  endtask

  task automatic count_high(input string tag, input int expv);
    int c;
    c = 0;
    repeat (256) begin
      cycle();
      c += int'(led_out[1]);
    end
    chk(tag, 32'(c), 32'(expv));
  endtask

  initial begin
    logic saved;
    int   guard;
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    writedata = '0; led_in = 4'hF;
    #1 reset_n = 1'b0; model_reset();
    #1 chk("led_during_reset", 32'(led_out), 32'h0);
    cycle(); cycle();
    reset_n = 1'b1;
    cycle();
    chk("led_after_release", 32'(led_out), 32'hF);
    address = 2'd0; cycle(); chk("rst_mode", readdata, 32'h0);
    address = 2'd1; cycle(); chk("rst_duty", readdata, 32'hFF);
    address = 2'd2; cycle(); chk("rst_blink_half", readdata, 32'd500);
    address = 2'd3; cycle(); chk("rst_status_phase", 32'(readdata[0]), 32'h1);

    // Blink LED0 with a two-tick half period
    wr(2'd2, 32'd2); wr(2'd0, 32'h01); led_in = 4'b0001; address = 2'd3;
    blink_period("blink_period_half2", 8);

    // PWM dimming on LED1 at several duties
    wr(2'd0, 32'h08); wr(2'd1, 32'd64); led_in = 4'b0010; address = 2'd3;
    cycle(); cycle();
    count_high("dim_duty64", 64);
    wr(2'd1, 32'd0); address = 2'd3; cycle(); cycle();
    count_high("dim_duty0", 0);
    wr(2'd1, 32'hFF); address = 2'd3; cycle(); cycle();
    count_high("dim_duty255", 256);

    // LED3 forced off; STATUS ignores writes
    wr(2'd0, 32'hC0); led_in = 4'b1000; cycle(); cycle();
    repeat (16) begin
      cycle();
      chk("led3_off", 32'(led_out[3]), 32'h0);
    end
    wr(2'd3, 32'hFFFF_FFFF); address = 2'd3; cycle();
    chk("status_ro_bits", readdata & 32'hFFFF_00FE, 32'h0);

    // Zero half period behaves as one tick
    wr(2'd0, 32'h01); led_in = 4'b0001; wr(2'd2, 32'd0); address = 2'd3;
    blink_period("blink_period_half0", 4);

    // Half-period write landing on a tick edge: no toggle that edge
    guard = 0;
    while ((m_cyc % DIV) != DIV - 1 && guard < 8) begin cycle(); guard++; end
    chk("tick_align_found", 32'(m_cyc % DIV), 32'(DIV - 1));
    saved = m_phase;
    wr(2'd2, 32'd1); address = 2'd3; #1;
    chk("tick_wr_no_toggle", 32'(readdata[0]), 32'(saved));
    repeat (12) cycle();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      led_in = 4'($urandom);
      address = 2'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        if (address == 2'd2) writedata = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        else writedata = $urandom;
        chipselect = 1'b1; write_n = 1'b0;
      end else begin
        writedata = $urandom; chipselect = 1'($urandom); write_n = 1'b1;
      end
      cycle();
      chipselect = 1'b0; write_n = 1'b1;
    end

    // Asynchronous reset while a blinking LED is lit
    wr(2'd0, 32'h01); wr(2'd2, 32'd1); led_in = 4'b0001; address = 2'd3;
    guard = 0;
    while (led_out[0] !== 1'b1 && guard < 20) begin cycle(); guard++; end
    chk("blink_led_high_before_reset", 32'(led_out[0]), 32'h1);
    #2 reset_n = 1'b0; model_reset();
    #1 chk("led_async_reset", 32'(led_out), 32'h0);
    address = 2'd0; #1 chk("mid_rst_mode", readdata, 32'h0);
    address = 2'd1; #1 chk("mid_rst_duty", readdata, 32'hFF);
    address = 2'd2; #1 chk("mid_rst_blink_half", readdata, 32'd500);
    address = 2'd3; #1 chk("mid_rst_status", readdata, 32'h1);
    cycle(); cycle();
    reset_n = 1'b1;
    repeat (20) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_fx_driver.md
Name: led_fx_driver

Overview:
Sits directly downstream of the 4-bit LED PIO output port and drives the board LED pins.
Each LED bit from the PIO can be passed through, blinked, PWM-dimmed or forced off, selected per LED.
Configured by Nios software through a small Avalon-MM slave that uses the same 2-bit address and zero-wait read style as the PIO.
All effects are timed from one shared prescaler.

Parameters:
NUM_LEDS, 4, number of LED channels (1..16)
PRESCALE_DIV, 50000, clk cycles per timebase tick (1 kHz at 50 MHz); minimum 2
PWM_W, 8, width of the PWM counter and the duty register

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data; combinational from address
led_in  in  NUM_LEDS  pattern from the LED PIO out_port
led_out  out  NUM_LEDS  registered LED pin drive

Behaviour:
- Reset values: led_out=0, MODE=0, DUTY=all ones, BLINK_HALF=500, prescaler=0, blink_cnt=0, blink_phase=1, pwm_cnt=0.
- Write condition: chipselect && !write_n. The register updates on that clk edge. No wait states.
- Register map:
  - addr 0 MODE, RW: 2 bits per LED at [2i+1:2i]; unused upper bits read 0.
  - addr 1 DUTY, RW: [PWM_W-1:0].
  - addr 2 BLINK_HALF, RW: [15:0], half-period in ticks.
  - addr 3 STATUS, RO: [0]=blink_phase, [PWM_W+7:8]=pwm_cnt. Writes to addr 3 are ignored.
- Reads: readdata = selected register, zero-extended. Unused bits are 0. Reads have no side effects.
- Mode encoding per LED:
  - 00 PASS: led_in[i].
  - 01 BLINK: led_in[i] & blink_phase.
  - 10 DIM: led_in[i] & pwm_on.
  - 11 OFF: 0.
- Output latency: led_out is registered, exactly 1 clk after any change of led_in, MODE, blink_phase or pwm_on.
- PWM:
  - pwm_cnt is free-running; it increments every clk and wraps at 2^PWM_W to 0.
  - pwm_on = (pwm_cnt < DUTY), except DUTY = all ones forces pwm_on=1 (true 100%).
  - DUTY=0 gives pwm_on always 0.
- Prescaler:
  - Counts 0..PRESCALE_DIV-1 and wraps.
  - tick is a 1-cycle pulse when the count equals PRESCALE_DIV-1.
- Blink:
  - half_eff = max(BLINK_HALF, 1).
  - On tick: if blink_cnt == half_eff-1, toggle blink_phase and clear blink_cnt; else increment blink_cnt.
  - If blink_cnt > half_eff-1 after BLINK_HALF is reduced, the compare is >=, so the next tick toggles and clears.
- Simultaneous events:
  - A BLINK_HALF write clears blink_cnt and wins over a tick in the same cycle; that tick is lost and the phase is unchanged.
  - A DUTY or MODE write takes effect on led_out 2 clks after the write edge (register, then output flop).
- Reset mid-operation: all state returns asynchronously to the reset values. led_out=0 immediately on reset_n low.

Decomposition:
- Shared package led_fx_pkg:
  - register address constants REG_MODE=0, REG_DUTY=1, REG_BLINK_HALF=2, REG_STATUS=3;
  - mode localparams MODE_PASS/BLINK/DIM/OFF;
  - reset constants BLINK_HALF_RST=500.
- One sub-module: led_fx_timebase. It contains the prescaler, blink counter and blink_phase. Inputs are clk, reset_n, blink_half, blink_half_wr. Outputs are tick and blink_phase.
- The PWM counter, the register file and the output mux stay in the top.

Test Plan (PRESCALE_DIV=4, NUM_LEDS=4):
- Reset, then led_in=4'b1111 with MODE=0 -> led_out=0 during reset; led_out=4'b1111 one clk after release; readback shows MODE=0, DUTY=0xFF, BLINK_HALF=500, STATUS[0]=1.
- Write BLINK_HALF=2, MODE=0x01 (LED0 blink), led_in=4'b0001 -> led_out[0] toggles every 8 clks (2 ticks x 4); STATUS[0] tracks the phase.
- Write MODE=0x08 (LED1 dim), DUTY=64, led_in=4'b0010 -> over 256 clks, led_out[1] high exactly 64 cycles; DUTY=0 gives 0 cycles; DUTY=0xFF gives 256 cycles.
- Write MODE=0xC0 (LED3 off), led_in=4'b1000 -> led_out[3]=0 permanently; the write to addr 3 leaves STATUS unchanged.
- Write BLINK_HALF=0 -> treated as 1; blink toggles every 4 clks. Write BLINK_HALF in the same cycle as a tick -> blink_cnt=0 and no toggle on that cycle.
- Assert reset_n low mid-blink with led_out=1 -> led_out=0 asynchronously; all registers return to their reset values.
